// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipeline_hazard_ctrl #(
    parameter int         LOAD_STALL_CYCLES = 1,
    parameter int         MEM_TIMEOUT       = 255,
    parameter logic [4:0] ZERO_REG          = 5'd31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  idRn,
    input  logic [4:0]  idRm,
    input  logic        idUsesRn,
    input  logic        idUsesRm,
    input  logic [4:0]  exRd,
    input  logic        exMemRead,
    input  logic        exBrTaken,
    input  logic        memBusy,
    output logic        pcEnable,
    output logic        rfEnable,
    output logic        rfFlush,
    output logic        exEnable,
    output logic        exBubble,
    output logic        memEnable,
    output logic        wbBubble,
    output logic        pcRedirect,
    output logic        memTimeout,
    output logic [15:0] stallCount
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_LDSTALL = 2'd1;
    localparam logic [1:0] ST_MEMWAIT = 2'd2;

    localparam logic [3:0] LD_INIT = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [7:0] TO_MAX  = 8'(MEM_TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [3:0]  ld_cnt_q, ld_cnt_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;
    logic [15:0] stall_count_q, stall_count_d;

    logic hazard;
    logic in_ldstall;

    // Next-state and pipeline control decode; memBusy outranks everything, in every state
    always_comb begin
        hazard = exMemRead && (exRd != ZERO_REG) &&
                 ((idUsesRn && (idRn == exRd)) || (idUsesRm && (idRm == exRd)));
        // A MEMWAIT exit cycle behaves as the state it returns to
        in_ldstall = (state_q == ST_LDSTALL) ||
                     ((state_q == ST_MEMWAIT) && (ld_cnt_q != 4'd0));

        pcEnable   = 1'b1;
        rfEnable   = 1'b1;
        rfFlush    = 1'b0;
        exEnable   = 1'b1;
        exBubble   = 1'b0;
        memEnable  = 1'b1;
        wbBubble   = 1'b0;
        pcRedirect = 1'b0;

        state_d       = ST_RUN;
        ld_cnt_d      = ld_cnt_q;
        to_cnt_d      = 8'd0;
        mem_timeout_d = mem_timeout_q;

        if (memBusy) begin
            pcEnable  = 1'b0;
            rfEnable  = 1'b0;
            exEnable  = 1'b0;
            memEnable = 1'b0;
            wbBubble  = 1'b1;
            state_d   = ST_MEMWAIT;
            if (state_q == ST_MEMWAIT) begin
                to_cnt_d = (to_cnt_q >= TO_MAX) ? TO_MAX : to_cnt_q + 8'd1;
            end else begin
                to_cnt_d = 8'd1;
            end
        end else if (exBrTaken) begin
            pcRedirect = 1'b1;
            rfFlush    = 1'b1;
            exBubble   = 1'b1;
            ld_cnt_d   = 4'd0;
            state_d    = ST_RUN;
        end else if (in_ldstall) begin
            pcEnable = 1'b0;
            rfEnable = 1'b0;
            exBubble = 1'b1;
            ld_cnt_d = ld_cnt_q - 4'd1;
            state_d  = (ld_cnt_q == 4'd1) ? ST_RUN : ST_LDSTALL;
        end else if (hazard) begin
            pcEnable = 1'b0;
            rfEnable = 1'b0;
            exBubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                ld_cnt_d = LD_INIT;
                state_d  = ST_LDSTALL;
            end
        end

        if (memBusy && (to_cnt_d == TO_MAX)) begin
            mem_timeout_d = 1'b1;
        end

        stall_count_d = (!pcEnable && (stall_count_q != 16'hFFFF)) ?
                        stall_count_q + 16'd1 : stall_count_q;

        // Reset holds every stage closed and bubbled
        if (reset) begin
            pcEnable   = 1'b0;
            rfEnable   = 1'b0;
            rfFlush    = 1'b1;
            exEnable   = 1'b0;
            exBubble   = 1'b1;
            memEnable  = 1'b0;
            wbBubble   = 1'b1;
            pcRedirect = 1'b0;
        end

        memTimeout = mem_timeout_q;
        stallCount = stall_count_q;
    end

    // State and debug counters, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            ld_cnt_q      <= 4'd0;
            to_cnt_q      <= 8'd0;
            mem_timeout_q <= 1'b0;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            ld_cnt_q      <= ld_cnt_d;
            to_cnt_q      <= to_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [4:0] idRn, idRm, exRd;
    logic       idUsesRn, idUsesRm, exMemRead, exBrTaken, memBusy;

    // {pcEnable, rfEnable, rfFlush, exEnable, exBubble, memEnable, wbBubble, pcRedirect}
    wire [7:0]  a_o, b_o;
    wire        a_mt, b_mt;
    wire [15:0] a_sc, b_sc;

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(3), .ZERO_REG(5'd31)) dut_a (
        .clk(clk), .reset(reset), .idRn(idRn), .idRm(idRm), .idUsesRn(idUsesRn),
        .idUsesRm(idUsesRm), .exRd(exRd), .exMemRead(exMemRead), .exBrTaken(exBrTaken),
        .memBusy(memBusy), .pcEnable(a_o[7]), .rfEnable(a_o[6]), .rfFlush(a_o[5]),
        .exEnable(a_o[4]), .exBubble(a_o[3]), .memEnable(a_o[2]), .wbBubble(a_o[1]),
        .pcRedirect(a_o[0]), .memTimeout(a_mt), .stallCount(a_sc));

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(6), .ZERO_REG(5'd31)) dut_b (
        .clk(clk), .reset(reset), .idRn(idRn), .idRm(idRm), .idUsesRn(idUsesRn),
        .idUsesRm(idUsesRm), .exRd(exRd), .exMemRead(exMemRead), .exBrTaken(exBrTaken),
        .memBusy(memBusy), .pcEnable(b_o[7]), .rfEnable(b_o[6]), .rfFlush(b_o[5]),
        .exEnable(b_o[4]), .exBubble(b_o[3]), .memEnable(b_o[2]), .wbBubble(b_o[1]),
        .pcRedirect(b_o[0]), .memTimeout(b_mt), .stallCount(b_sc));

    localparam logic [7:0] O_RESET  = 8'b0010_1010;
    localparam logic [7:0] O_FREEZE = 8'b0000_0010;
    localparam logic [7:0] O_BRANCH = 8'b1111_1101;
    localparam logic [7:0] O_HAZARD = 8'b0001_1100;
    localparam logic [7:0] O_IDLE   = 8'b1101_0100;

    int checks = 0;
    int errors = 0;

    // Reference model: bubbles still owed, length of the current busy run,
    // sticky timeout and stall total, one set per instance
    int m_len[2] = '{1, 3};
    int m_to[2]  = '{3, 6};
    int m_bub[2];
    int m_run[2];
    int m_sticky[2];
    int m_scnt[2];

    function automatic bit is_hazard();
        return exMemRead && (exRd != 5'd31) &&
               ((idUsesRn && (idRn == exRd)) || (idUsesRm && (idRm == exRd)));
    endfunction

    function automatic logic [7:0] model_outs(input int k);
        if (reset)          return O_RESET;
        if (memBusy)        return O_FREEZE;
        if (exBrTaken)      return O_BRANCH;
        if (m_bub[k] > 0)   return O_HAZARD;
        if (is_hazard())    return O_HAZARD;
        return O_IDLE;
    endfunction

    task automatic model_edge(input int k, input logic [7:0] o);
        if (reset) begin
            m_bub[k] = 0; m_run[k] = 0; m_sticky[k] = 0; m_scnt[k] = 0;
        end else begin
            if (!o[7] && m_scnt[k] < 65535) m_scnt[k]++;
            if (memBusy) begin
                if (m_run[k] < 1000) m_run[k]++;
            end else begin
                m_run[k] = 0;
            end
            if (m_run[k] >= m_to[k]) m_sticky[k] = 1;
            if (!memBusy) begin
                if (exBrTaken)         m_bub[k] = 0;
                else if (m_bub[k] > 0) m_bub[k]--;
                else if (is_hazard())  m_bub[k] = m_len[k] - 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, check both instances mid-cycle, then advance
    task automatic cycle(input logic r, input logic bu, input logic br, input logic mr,
                         input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                         input logic un, input logic um);
        logic [7:0] ea, eb;
        reset = r; memBusy = bu; exBrTaken = br; exMemRead = mr;
        exRd = rd; idRn = rn; idRm = rm; idUsesRn = un; idUsesRm = um;
        @(negedge clk);
        ea = model_outs(0);
        eb = model_outs(1);
        chk("outs_a", {24'd0, a_o}, {24'd0, ea});
        chk("outs_b", {24'd0, b_o}, {24'd0, eb});
        chk("timeout_a", {31'd0, a_mt}, 32'(m_sticky[0]));
        chk("timeout_b", {31'd0, b_mt}, 32'(m_sticky[1]));
        chk("stallcnt_a", {16'd0, a_sc}, 32'(m_scnt[0]));
        chk("stallcnt_b", {16'd0, b_sc}, 32'(m_scnt[1]));
        model_edge(0, ea);
        model_edge(1, eb);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0);
    endtask

    initial begin
        reset = 1; memBusy = 0; exBrTaken = 0; exMemRead = 0;
        exRd = 0; idRn = 0; idRm = 0; idUsesRn = 0; idUsesRm = 0;
        for (int k = 0; k < 2; k++) begin
            m_bub[k] = 0; m_run[k] = 0; m_sticky[k] = 0; m_scnt[k] = 0;
        end
        @(posedge clk); #1;

        // reset state
        cycle(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        cycle(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(1);

        // load-use, single bubble on instance a
        cycle(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        idle(1);
        chk("ldu_stallcnt_a", {16'd0, a_sc}, 32'd1);
        idle(3);

        // Rm match, XZR destination, non-use of a matching register
        cycle(0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 1);
        idle(3);
        cycle(0, 0, 0, 1, 5'd31, 5'd31, 5'd31, 1, 1);
        cycle(0, 0, 0, 1, 5'd5, 5'd5, 5'd5, 0, 0);
        idle(1);

        // branch and hazard together
        cycle(0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        idle(1);

        // 4-cycle memory wait; instance b stays below its timeout
        cycle(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(1);
        chk("wait4_stallcnt_b", {16'd0, b_sc}, 32'd4);
        chk("wait4_timeout_b", {31'd0, b_mt}, 32'd0);

        // 5-cycle wait crosses instance a's timeout, flag sticks
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(2);
        chk("sticky_timeout_a", {31'd0, a_mt}, 32'd1);

        // three-cycle load stall interrupted by a memory wait
        cycle(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        cycle(0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 1, 0);
        cycle(0, 1, 0, 1, 5'd9, 5'd9, 5'd0, 1, 0);
        cycle(0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 1, 0);
        cycle(0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 1, 0);
        idle(2);
        chk("ldmem_stallcnt_b", {16'd0, b_sc}, 32'd4);

        // branch in the middle of a load stall
        cycle(0, 0, 0, 1, 5'd3, 5'd0, 5'd3, 0, 1);
        cycle(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(2);

        // reset in the middle of a load stall
        cycle(0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 1, 0);
        cycle(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(1);
        chk("rst_mid_stallcnt_b", {16'd0, b_sc}, 32'd0);
        chk("rst_mid_timeout_a", {31'd0, a_mt}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] rd;
            rd = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'(4 + $urandom_range(0, 2));
            cycle(($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 20),
                  ($urandom_range(0, 99) < 12),
                  ($urandom_range(0, 99) < 50),
                  rd,
                  5'(4 + $urandom_range(0, 2)),
                  ($urandom_range(0, 5) == 0) ? 5'd31 : 5'(4 + $urandom_range(0, 2)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
